regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Write-port initiator for the 32×32 register file: the single source of RegWrite/WriteReg/WriteData. It merges the ALU result path (no backpressure, highest priority) with the load-data path (valid/ready handshake, buffered in a small FIFO). It keeps a per-register pending-load scoreboard that the issue stage queries for load-use stalls. Outputs change on posedge CLK, so the register file commits each write on the negedge inside the same cycle.

## Interface
- DEPTH, 4: load FIFO entries, power of two, 2..16.
- CLK  in  1  clock, posedge active.
- RST  in  1  synchronous, active-high reset.
- AluValid  in  1  ALU result present this cycle; never stalled.
- AluReg  in  5  ALU destination register.
- AluData  in  32  ALU result.
- LdValid  in  1  load data offered.
- LdReady  out  1  load FIFO can accept.
- LdReg  in  5  load destination register.
- LdData  in  32  load data.
- PendSet  in  1  load issued this cycle; mark PendReg pending.
- PendReg  in  5  register being marked.
- QueryReg1, QueryReg2  in  5  issue-stage source registers.
- Busy1, Busy2  out  1  queried register has a pending load (combinational).
- RegWrite  out  1  register-file write enable (registered).
- WriteReg  out  5  register-file write address (registered).
- WriteData  out  32  register-file write data (registered).

## Operation
- Load handshake: a transfer occurs at a posedge where LdValid && LdReady. The entry {LdReg, LdData} is pushed to the FIFO tail.
- LdReady = !RST && (count != DEPTH). It depends on count only; a same-cycle pop does not raise it.
- Per-cycle select:
  - AluValid: output the ALU write; FIFO untouched.
  - else FIFO non-empty: pop the head and output it.
  - else: RegWrite<=0.
  - WriteReg/WriteData hold their previous value when idle.
- Register 0: a selected write with register 0 is consumed normally (a popped entry is still popped) but drives RegWrite<=0. PendSet with PendReg=0 is ignored.
- Scoreboard: 32 pending bits.
  - PendSet sets bit PendReg.
  - Popping a load entry clears bit LdReg of that entry.
  - Set and clear of the same register at the same edge: set wins.
- Busy1 = pending[QueryReg1]; Busy2 = pending[QueryReg2]. Register 0 always reads 0.
- Ordering: the issue stage does not issue an ALU op targeting a register that is pending. The block does not reorder or check this.
- FIFO: circular buffer with head/tail pointers of log2(DEPTH) bits that wrap at DEPTH; count is log2(DEPTH)+1 bits. Simultaneous push and pop when full is impossible because LdReady=0. When empty, pop is never selected.

## Timing
- Reset values (all at a posedge with RST=1): RegWrite=0, WriteReg=0, WriteData=0, FIFO empty, all pending bits 0, LdReady=0.
- LdReady returns to 1 in the first cycle with RST=0.
- Reset mid-operation discards FIFO contents and pending bits; no write is emitted at that edge.
- ALU latency: AluValid sampled at edge t gives RegWrite=1 during cycle t..t+1; the register file commits at the following negedge.
- Load latency (macro off): accepted at edge t, earliest write output at edge t+1 (2-cycle visible latency). Each ALU cycle adds one cycle of delay.
- Throughput: one register-file write per cycle maximum. Loads are starved while AluValid stays high; backpressure reaches the load source through LdReady.

## Configuration
- WB_LD_BYPASS_EN defined: when FIFO is empty, AluValid=0 and the handshake completes, the load goes straight to the output at the same edge. The FIFO is not written, and pending is cleared at that edge (set still wins). Load latency becomes 1.
- Not defined: every load passes through the FIFO (latency 2).

## Test plan
- Reset: assert RST for 2 cycles with LdValid=1, AluValid=1 -> RegWrite=0, WriteReg=0, WriteData=0, LdReady=0; LdReady=1 in the cycle after release.
- ALU path: AluValid with AluReg=5, AluData=0xDEADBEEF -> next cycle RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF; register-file readback of r5 = 0xDEADBEEF.
- Priority/fill: hold AluValid for 6 cycles while offering 5 loads with DEPTH=4 -> LdReady drops after 4 accepts. Loads are written in order after AluValid drops; the 5th is accepted once LdReady rises.
- Scoreboard: PendSet r7, QueryReg1=7 -> Busy1=1 until the edge popping the r7 load, then 0. PendSet r7 at that same edge -> Busy1 stays 1.
- Register 0: load to r0 and ALU to r0 -> RegWrite stays 0, FIFO count decrements; PendSet r0 -> Busy=0.
- Bypass (WB_LD_BYPASS_EN): idle block, load r3=0x12345678 -> RegWrite=1, WriteReg=3 one cycle after the handshake edge; without the macro, two cycles.

Source files
------------

// File: rtl/regfile_writeback.sv
// ============================================================================
// Module   : regfile_writeback
// Purpose  : Register-file write-port initiator. It merges the ALU result path
//            (highest priority) with buffered load data, and keeps a
//            per-register pending-load scoreboard.
// Option   : WB_LD_BYPASS_EN lets a load skip the empty FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_writeback #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        AluValid,
  input  logic [4:0]  AluReg,
  input  logic [31:0] AluData,
  input  logic        LdValid,
  output logic        LdReady,
  input  logic [4:0]  LdReg,
  input  logic [31:0] LdData,
  input  logic        PendSet,
  input  logic [4:0]  PendReg,
  input  logic [4:0]  QueryReg1,
  input  logic [4:0]  QueryReg2,
  output logic        Busy1,
  output logic        Busy2,
  output logic        RegWrite,
  output logic [4:0]  WriteReg,
  output logic [31:0] WriteData
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  logic [4:0]    r_mem_reg  [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic [31:0]   r_pend;
  logic          r_regwrite;
  logic [4:0]    r_wreg;
  logic [31:0]   r_wdata;

  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_byp;
  logic          w_fifo_wr;
  logic [4:0]    w_head_reg;
  logic [31:0]   w_head_data;
  logic [31:0]   w_clr_vec;
  logic [31:0]   w_set_vec;
  logic [31:0]   w_pend_nxt;
  logic          w_sel;
  logic [4:0]    w_sel_reg;
  logic [31:0]   w_sel_data;

  assign w_empty     = (r_count == '0);
  assign LdReady     = !RST && (r_count != C_FULL);
  assign w_push      = LdValid && LdReady;
  assign w_pop       = !AluValid && !w_empty;
  assign w_head_reg  = r_mem_reg[r_head];
  assign w_head_data = r_mem_data[r_head];

`ifdef WB_LD_BYPASS_EN
  assign w_byp = !AluValid && w_empty && w_push;
`else
  assign w_byp = 1'b0;
`endif

  assign w_fifo_wr = w_push && !w_byp;

  always_comb begin
    w_sel      = 1'b0;
    w_sel_reg  = '0;
    w_sel_data = '0;
    if (AluValid) begin
      w_sel      = 1'b1;
      w_sel_reg  = AluReg;
      w_sel_data = AluData;
    end else if (w_pop) begin
      w_sel      = 1'b1;
      w_sel_reg  = w_head_reg;
      w_sel_data = w_head_data;
    end else if (w_byp) begin
      w_sel      = 1'b1;
      w_sel_reg  = LdReg;
      w_sel_data = LdData;
    end
  end

  // Clears come from the load leaving toward the register file; a same-edge
  // set is OR-ed in afterwards so it wins.
  always_comb begin
    w_clr_vec = '0;
    w_set_vec = '0;
    if (w_pop) w_clr_vec[w_head_reg] = 1'b1;
    if (w_byp) w_clr_vec[LdReg] = 1'b1;
    if (PendSet && (PendReg != 5'd0)) w_set_vec[PendReg] = 1'b1;
    w_pend_nxt = (r_pend & ~w_clr_vec) | w_set_vec;
  end

  always_ff @(posedge CLK) begin
    if (w_fifo_wr && !RST) begin
      r_mem_reg[r_tail]  <= LdReg;
      r_mem_data[r_tail] <= LdData;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_pend     <= '0;
      r_regwrite <= 1'b0;
      r_wreg     <= '0;
      r_wdata    <= '0;
    end else begin
      if (w_fifo_wr) r_tail <= r_tail + 1'b1;
      if (w_pop)     r_head <= r_head + 1'b1;
      case ({w_fifo_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_pend     <= w_pend_nxt;
      r_regwrite <= w_sel && (w_sel_reg != 5'd0);
      if (w_sel) begin
        r_wreg  <= w_sel_reg;
        r_wdata <= w_sel_data;
      end
    end
  end

  assign Busy1     = r_pend[QueryReg1] && (QueryReg1 != 5'd0);
  assign Busy2     = r_pend[QueryReg2] && (QueryReg2 != 5'd0);
  assign RegWrite  = r_regwrite;
  assign WriteReg  = r_wreg;
  assign WriteData = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_regfile_writeback.sv
// ============================================================================
// Module   : tb_regfile_writeback
// Purpose  : Self-checking bench for regfile_writeback against a queue-based
//            reference model. It uses directed steps followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_writeback;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        AluValid, LdValid, PendSet;
  logic [4:0]  AluReg, LdReg, PendReg, QueryReg1, QueryReg2;
  logic [31:0] AluData, LdData;
  logic        LdReady, Busy1, Busy2, RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;

  regfile_writeback #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .AluValid(AluValid), .AluReg(AluReg), .AluData(AluData),
    .LdValid(LdValid), .LdReady(LdReady), .LdReg(LdReg), .LdData(LdData),
    .PendSet(PendSet), .PendReg(PendReg),
    .QueryReg1(QueryReg1), .QueryReg2(QueryReg2),
    .Busy1(Busy1), .Busy2(Busy2),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData)
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic [4:0] r; logic [31:0] d; } ld_t;
  ld_t         m_q[$];
  logic        m_pend [32];
  logic        e_rw;
  logic [4:0]  e_wr;
  logic [31:0] e_wd;
  logic        m_accepted;
  logic [31:0] m_rf [32];

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs were applied 1 time unit after the previous edge; the next step
  // checks the combinational outputs, then advances the model and the DUT
  // by one edge and checks the registered outputs.
  task automatic cycle();
    ld_t e;
    logic sel;
    logic [4:0] sreg;
    logic [31:0] sdata;
    logic push;
    #1;
    chk("LdReady", 32'(LdReady), 32'(!RST && (m_q.size() < DEPTH)));
    chk("Busy1", 32'(Busy1), 32'(QueryReg1 != 0 && m_pend[QueryReg1]));
    chk("Busy2", 32'(Busy2), 32'(QueryReg2 != 0 && m_pend[QueryReg2]));
    @(posedge CLK);
    m_accepted = 1'b0;
    if (RST) begin
      m_q.delete();
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      e_rw = 1'b0; e_wr = '0; e_wd = '0;
    end else begin
      push = LdValid && (m_q.size() < DEPTH);
      m_accepted = push;
      sel = 1'b0; sreg = '0; sdata = '0;
      if (AluValid) begin
        sel = 1'b1; sreg = AluReg; sdata = AluData;
      end else if (m_q.size() > 0) begin
        e = m_q.pop_front();
        sel = 1'b1; sreg = e.r; sdata = e.d;
        m_pend[e.r] = 1'b0;
      end
`ifdef WB_LD_BYPASS_EN
      else if (push) begin
        sel = 1'b1; sreg = LdReg; sdata = LdData;
        m_pend[LdReg] = 1'b0;
        push = 1'b0;
      end
`endif
      if (push) m_q.push_back('{r: LdReg, d: LdData});
      if (PendSet && PendReg != 0) m_pend[PendReg] = 1'b1;
      e_rw = sel && (sreg != 0);
      if (sel) begin e_wr = sreg; e_wd = sdata; end
      if (e_rw) m_rf[sreg] = sdata;
    end
    #1;
    chk("RegWrite", 32'(RegWrite), 32'(e_rw));
    if (e_rw || RST) begin
      chk("WriteReg", 32'(WriteReg), 32'(e_wr));
      chk("WriteData", WriteData, e_wd);
    end
  endtask

  task automatic idle_inputs();
    AluValid = 0; AluReg = 0; AluData = 0;
    LdValid = 0; LdReg = 0; LdData = 0;
    PendSet = 0; PendReg = 0;
  endtask

  initial begin
    int k;
    RST = 1; idle_inputs(); QueryReg1 = 0; QueryReg2 = 0;
    for (int i = 0; i < 32; i++) begin m_pend[i] = 1'b0; m_rf[i] = '0; end
    e_rw = 0; e_wr = 0; e_wd = 0;

    // Reset with both paths active
    AluValid = 1; AluReg = 9; AluData = 32'h5555_AAAA;
    LdValid = 1; LdReg = 4; LdData = 32'h1111_2222;
    cycle(); cycle();
    RST = 0; idle_inputs();
    cycle();

    // ALU path
    AluValid = 1; AluReg = 5; AluData = 32'hDEADBEEF;
    cycle();
    AluValid = 0;
    chk("rf_r5", m_rf[5], 32'hDEADBEEF);
    cycle();

    // Priority / fill: six ALU cycles while offering five loads
    k = 0;
    for (int c = 0; c < 14; c++) begin
      AluValid = (c < 6); AluReg = 5'(20 + c); AluData = 32'hA000_0000 + c;
      LdValid = (k < 5); LdReg = 5'(10 + k); LdData = 32'h0000_1000 + k;
      cycle();
      if (m_accepted) k++;
    end
    chk("fill_accepts", k, 5);
    idle_inputs();
    cycle();

    // Scoreboard: pend r7, then load r7 pops with a same-edge set
    QueryReg1 = 7; QueryReg2 = 0;
    PendSet = 1; PendReg = 7; cycle();
    PendSet = 0;
    AluValid = 1; AluReg = 2; AluData = 32'h22;
    LdValid = 1; LdReg = 7; LdData = 32'h7777;
    cycle();
    idle_inputs(); PendSet = 1; PendReg = 7;
    cycle();
    chk("set_wins", 32'(Busy1), 32'd1);
    idle_inputs(); LdValid = 1; LdReg = 7; LdData = 32'h7778;
    cycle();
    idle_inputs();
    cycle(); cycle();
    chk("cleared", 32'(Busy1), 32'd0);

    // Register 0 handling
    LdValid = 1; LdReg = 0; LdData = 32'hBAD0; PendSet = 1; PendReg = 0;
    QueryReg2 = 0; cycle();
    idle_inputs(); AluValid = 1; AluReg = 0; AluData = 32'hBAD1;
    cycle();
    idle_inputs(); cycle(); cycle();

    // Bypass latency check: idle block, single load to r3
    LdValid = 1; LdReg = 3; LdData = 32'h12345678;
    cycle();
    idle_inputs();
    cycle(); cycle();

    // Randomized traffic over a small register window to force collisions
    for (int c = 0; c < 400; c++) begin
      RST       = ($urandom_range(0, 79) == 0);
      AluValid  = ($urandom_range(0, 2) == 0);
      AluReg    = 5'($urandom_range(0, 7));
      AluData   = $urandom;
      LdValid   = ($urandom_range(0, 1) == 0);
      LdReg     = 5'($urandom_range(0, 7));
      LdData    = $urandom;
      PendSet   = ($urandom_range(0, 2) == 0);
      PendReg   = 5'($urandom_range(0, 7));
      QueryReg1 = 5'($urandom_range(0, 7));
      QueryReg2 = 5'($urandom_range(0, 31));
      cycle();
    end
    RST = 0; idle_inputs();
    for (int c = 0; c < 8; c++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
